// File: rtl/charlieplex_pkg.sv
// Shared types and elaboration-time helpers for the charlieplexed PWM display.
package charlieplex_pkg;

   typedef enum logic {
      ST_BLANK = 1'b0,
      ST_LIGHT = 1'b1
   } state_t;

   // Smallest pin count p with p*(p-1) >= pixelcount.
   function automatic int unsigned pincount(input int unsigned pixelcount);
      int unsigned p;
      p = 2;
      for (int unsigned i = 2; i < 256; i++) begin
         if (i * (i - 1) < pixelcount) p = i + 1;
      end
      return p;
   endfunction

   // LED number for anode column x and cathode row y (x != y).
   function automatic int unsigned led_index(input int unsigned x, input int unsigned y,
                                             input int unsigned pc);
      if (x > y) return (pc - 1) * x + y;
      else       return (pc - 1) * x + y - 1;
   endfunction

endpackage

// File: rtl/charlieplex_decode.sv
// Combinational pixel-to-pin decoder; the parent registers its outputs.
module charlieplex_decode
   import charlieplex_pkg::*;
#(
   parameter int unsigned PIXELCOUNT = 12,
   parameter int unsigned PINCOUNT   = 4,
   parameter int unsigned AW         = 4
) (
   input  logic [AW-1:0]       pixel,
   input  logic                on,
   output logic [PINCOUNT-1:0] out_en_c,
   output logic [PINCOUNT-1:0] out_value_c
);

   // Search the (column,row) pair that maps to the selected pixel.
   always_comb begin
      out_en_c    = '0;
      out_value_c = '0;
      for (int unsigned x = 0; x < PINCOUNT; x++) begin
         for (int unsigned y = 0; y < PINCOUNT; y++) begin
            if (on && (x != y) && (led_index(x, y, PINCOUNT) == 32'(pixel)) &&
                (32'(pixel) < PIXELCOUNT)) begin
               out_en_c    = (PINCOUNT'(1) << x) | (PINCOUNT'(1) << y);
               out_value_c = PINCOUNT'(1) << x;
            end
         end
      end
   end

endmodule

// File: rtl/charlieplex_pwm_display.sv
// Charlieplexed LED scanner with per-pixel PWM and a double-buffered framebuffer.
module charlieplex_pwm_display
   import charlieplex_pkg::*;
#(
   parameter int unsigned PIXELCOUNT = 12,
   parameter int unsigned BPP        = 4,
   parameter int unsigned PRESCALE   = 16,
   parameter int unsigned BLANK      = 2,
   localparam int unsigned PINCOUNT  = pincount(PIXELCOUNT),
   localparam int unsigned AW        = $clog2(PIXELCOUNT)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                enable,
   input  logic                wr_en,
   input  logic [AW-1:0]       wr_addr,
   input  logic [BPP-1:0]      wr_data,
   input  logic                swap_req,
   output logic                swap_ack,
   output logic                frame_start,
   output logic [PINCOUNT-1:0] out_en,
   output logic [PINCOUNT-1:0] out_value
);

   localparam int unsigned STEPS = (1 << BPP) - 1;
   localparam int unsigned CMAX  = (PRESCALE > BLANK) ? PRESCALE : BLANK;
   localparam int unsigned CW    = $clog2(CMAX + 1);

   state_t         state;
   logic [AW-1:0]  pixel;
   logic [CW-1:0]  cnt;
   logic [BPP-1:0] step;
   logic [BPP-1:0] cur_bright;
   logic           front_sel;
   logic           swap_pending;
   logic [BPP-1:0] buf0 [PIXELCOUNT];
   logic [BPP-1:0] buf1 [PIXELCOUNT];

   logic                blank_done_c;
   logic                step_done_c;
   logic                slot_done_c;
   logic                wrap_c;
   logic                lit_c;
   logic                wr_ok_c;
   logic [BPP-1:0]      front_val_c;
   logic [PINCOUNT-1:0] dec_en_c;
   logic [PINCOUNT-1:0] dec_value_c;

   assign blank_done_c = (state == ST_BLANK) && (cnt == CW'(BLANK - 1));
   assign step_done_c  = (state == ST_LIGHT) && (cnt == CW'(PRESCALE - 1));
   assign slot_done_c  = step_done_c && (step == BPP'(STEPS - 1));
   assign wrap_c       = slot_done_c && (pixel == AW'(PIXELCOUNT - 1));
   assign lit_c        = (state == ST_LIGHT) && enable && (step < cur_bright);
   assign wr_ok_c      = wr_en && (32'(wr_addr) < PIXELCOUNT);
   assign front_val_c  = front_sel ? buf1[pixel] : buf0[pixel];

   charlieplex_decode #(
      .PIXELCOUNT (PIXELCOUNT),
      .PINCOUNT   (PINCOUNT),
      .AW         (AW)
   ) u_decode (
      .pixel       (pixel),
      .on          (lit_c),
      .out_en_c    (dec_en_c),
      .out_value_c (dec_value_c)
   );

   // Scan FSM: blanking, then PWM steps of the current pixel; wraps to pixel 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_BLANK;
         pixel       <= '0;
         cnt         <= '0;
         step        <= '0;
         cur_bright  <= '0;
         frame_start <= 1'b0;
      end else begin
         frame_start <= 1'b0;
         case (state)
            ST_BLANK: begin
               if (blank_done_c) begin
                  state      <= ST_LIGHT;
                  cnt        <= '0;
                  step       <= '0;
                  cur_bright <= front_val_c;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            ST_LIGHT: begin
               if (step_done_c) begin
                  cnt <= '0;
                  if (slot_done_c) begin
                     state <= ST_BLANK;
                     step  <= '0;
                     if (wrap_c) begin
                        pixel       <= '0;
                        frame_start <= 1'b1;
                     end else begin
                        pixel <= pixel + AW'(1);
                     end
                  end else begin
                     step <= step + BPP'(1);
                  end
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: state <= ST_BLANK;
         endcase
      end
   end

   // Sticky swap request, honoured only in the wrap cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         front_sel    <= 1'b0;
         swap_pending <= 1'b0;
         swap_ack     <= 1'b0;
      end else begin
         swap_ack <= 1'b0;
         if (wrap_c && (swap_pending || swap_req)) begin
            front_sel    <= ~front_sel;
            swap_pending <= 1'b0;
            swap_ack     <= 1'b1;
         end else if (swap_req) begin
            swap_pending <= 1'b1;
         end
      end
   end

   // Host writes always target the current back buffer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < PIXELCOUNT; i++) begin
            buf0[i] <= '0;
            buf1[i] <= '0;
         end
      end else if (wr_ok_c) begin
         if (front_sel) buf0[wr_addr] <= wr_data;
         else           buf1[wr_addr] <= wr_data;
      end
   end

   // Registered pin drive.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_en    <= '0;
         out_value <= '0;
      end else begin
         out_en    <= dec_en_c;
         out_value <= dec_value_c;
      end
   end

endmodule
